piso_tx: RTL

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_pkg.sv | 9 +
 rtl/piso_tx.sv | 63 ++++++
 2 files changed

// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state type for the parallel-in serial-out transmitter
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter with stall and back-to-back loads
module piso_tx
    import piso_pkg::*;
#(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [N-1:0] D,
    input  logic         LOAD,
    input  logic         EN,
    output logic         READY,
    output logic         SOUT,
    output logic         SVALID,
    output logic         DONE
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t          state;
    logic [N-1:0]    sreg;
    logic [CW-1:0]   cnt;
    logic            last_bit;
    logic            do_load;
    logic [N-1:0]    sreg_shifted;

    // The final bit of the frame is being consumed this cycle; a new word may be accepted alongside it
    always_comb begin
        last_bit     = (state == SHIFT) && (cnt == LAST) && EN;
        READY        = (state == IDLE) || last_bit;
        DONE         = last_bit;
        do_load      = LOAD && READY;
        SVALID       = (state == SHIFT);
        SOUT         = 1'b0;
        if (state == SHIFT) begin
            SOUT = LSB_FIRST ? sreg[0] : sreg[N-1];
        end
        sreg_shifted = LSB_FIRST ? {1'b0, sreg[N-1:1]} : {sreg[N-2:0], 1'b0};
    end

    // Frame sequencing: reset wins, then a load (possibly on the DONE cycle), then shift or finish
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else if (do_load) begin
            state <= SHIFT;
            sreg  <= D;
            cnt   <= '0;
        end else if ((state == SHIFT) && EN) begin
            if (cnt == LAST) begin
                state <= IDLE;
            end else begin
                sreg <= sreg_shifted;
                cnt  <= cnt + 1'b1;
            end
        end
    end

endmodule
